// File: rtl/mismatch_monitor_pkg.sv
// Shared types and helpers for the reference/DUT mismatch monitor.
// Field widths are maxima; instances use the low CNT_W / TS_W bits.
package mismatch_monitor_pkg;

  localparam int MAX_CNT_W = 32;
  localparam int MAX_TS_W  = 64;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] errors;
    logic [MAX_TS_W-1:0]  first_time;
    logic                 first_valid;
  } ch_stats_t;

  localparam ch_stats_t RD_ZERO = '0;

  // Increment v, holding at 2^w-1 instead of wrapping.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(
    input logic [MAX_CNT_W-1:0] v,
    input int                   w
  );
    logic [MAX_CNT_W-1:0] lim;
    lim = (w >= MAX_CNT_W) ? '1
        : ((MAX_CNT_W'(1) << w) - MAX_CNT_W'(1));
    return (v >= lim) ? v : v + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mismatch_channel.sv
// One channel: saturating error counter and first-mismatch capture.
// First-time capture exists only with MISMATCH_MONITOR_FIRST_TIME_EN.
module mismatch_channel
  import mismatch_monitor_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            clear,
  input  logic            hit,
  input  logic            valid_q,
  input  logic [TS_W-1:0] ts_q,
  output ch_stats_t       stats
);

  logic [CNT_W-1:0]     errors;
  logic [MAX_CNT_W-1:0] err_inc;
  logic                 unused_inc;

  assign err_inc    = sat_inc(MAX_CNT_W'(errors), CNT_W);
  assign unused_inc = ^err_inc;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      errors <= '0;
    end else if (clear) begin
      errors <= '0;
    end else if (valid_q && hit) begin
      errors <= err_inc[CNT_W-1:0];
    end
  end

`ifdef MISMATCH_MONITOR_FIRST_TIME_EN
  logic [TS_W-1:0] first_time;
  logic            first_valid;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      first_time  <= '0;
      first_valid <= 1'b0;
    end else if (clear) begin
      first_time  <= '0;
      first_valid <= 1'b0;
    end else if (valid_q && hit && !first_valid) begin
      first_time  <= ts_q;
      first_valid <= 1'b1;
    end
  end

  always_comb begin
    stats             = RD_ZERO;
    stats.errors      = MAX_CNT_W'(errors);
    stats.first_time  = MAX_TS_W'(first_time);
    stats.first_valid = first_valid;
  end
`else
  logic unused_ts;
  assign unused_ts = ^ts_q;

  always_comb begin
    stats        = RD_ZERO;
    stats.errors = MAX_CNT_W'(errors);
  end
`endif

endmodule

// File: rtl/mismatch_monitor.sv
// Two-stage reference/DUT mismatch monitor with per-channel stats.
// Define MISMATCH_MONITOR_FIRST_TIME_EN for first-mismatch timestamps.
module mismatch_monitor
  import mismatch_monitor_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 1,
  parameter int CNT_W  = 16,
  parameter int TS_W   = 32,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    clear,
  input  logic                    sample_valid,
  input  logic [NUM_CH*WIDTH-1:0] ref_data,
  input  logic [NUM_CH*WIDTH-1:0] dut_data,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [NUM_CH-1:0]       ch_mismatch,
  output logic [CNT_W-1:0]        sample_count,
  output logic [CNT_W-1:0]        total_errors,
  output logic                    any_error,
  output logic [CNT_W-1:0]        rd_errors,
  output logic [TS_W-1:0]         rd_first_time,
  output logic                    rd_first_valid
);

  logic [NUM_CH-1:0]    mm;
  logic [NUM_CH-1:0]    mm_q;
  logic                 valid_q;
  logic [TS_W-1:0]      ts_q;
  logic [MAX_CNT_W-1:0] sc_inc;
  logic [MAX_CNT_W-1:0] te_inc;
  ch_stats_t            stats [NUM_CH];
  ch_stats_t            sel;
  logic                 unused_bits;

  always_comb begin
    mm = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mm[i] = ref_data[i*WIDTH +: WIDTH] != dut_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mm_q    <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      mm_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= sample_valid;
      if (sample_valid) begin
        mm_q <= mm;
      end
    end
  end

`ifdef MISMATCH_MONITOR_FIRST_TIME_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running; ts_q is the count at the sample's acceptance edge.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else if (clear) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (sample_valid) begin
        ts_q <= ts_cnt;
      end
    end
  end
`else
  assign ts_q = '0;
`endif

  assign sc_inc = sat_inc(MAX_CNT_W'(sample_count), CNT_W);
  assign te_inc = sat_inc(MAX_CNT_W'(total_errors), CNT_W);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sample_count <= '0;
      total_errors <= '0;
      any_error    <= 1'b0;
    end else if (clear) begin
      sample_count <= '0;
      total_errors <= '0;
      any_error    <= 1'b0;
    end else if (valid_q) begin
      sample_count <= sc_inc[CNT_W-1:0];
      if (|mm_q) begin
        total_errors <= te_inc[CNT_W-1:0];
        any_error    <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mismatch_channel #(
      .CNT_W(CNT_W),
      .TS_W (TS_W)
    ) u_ch (
      .clk    (clk),
      .areset (areset),
      .clear  (clear),
      .hit    (mm_q[g]),
      .valid_q(valid_q),
      .ts_q   (ts_q),
      .stats  (stats[g])
    );
  end

  // Out-of-range selects fall through to the zero constant.
  always_comb begin
    sel = RD_ZERO;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(rd_sel) == i) begin
        sel = stats[i];
      end
    end
  end

  assign ch_mismatch    = mm_q;
  assign rd_errors      = sel.errors[CNT_W-1:0];
  assign rd_first_time  = sel.first_time[TS_W-1:0];
  assign rd_first_valid = sel.first_valid;
  assign unused_bits    = ^{sc_inc, te_inc, sel};

endmodule

// File: tb/tb_mismatch_monitor.sv
// Scoreboard bench for mismatch_monitor: a 4-channel instance checked
// against a cycle model, plus a 3-channel CNT_W=4 instance.
module tb_mismatch_monitor;

`ifdef MISMATCH_MONITOR_FIRST_TIME_EN
  localparam bit FT_EN = 1'b1;
`else
  localparam bit FT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset, clear, sample_valid;
  logic [3:0]  ref_data, dut_data;
  logic [1:0]  rd_sel;
  logic [3:0]  ch_mismatch;
  logic [15:0] sample_count, total_errors, rd_errors;
  logic        any_error, rd_first_valid;
  logic [31:0] rd_first_time;

  logic        s_valid;
  logic [2:0]  s_ref, s_dut;
  logic [1:0]  s_rd_sel;
  logic [2:0]  s_ch;
  logic [3:0]  s_sc, s_te, s_rde;
  logic        s_ae, s_rdv;
  logic [7:0]  s_rdt;

  mismatch_monitor #(
    .NUM_CH(4), .WIDTH(1), .CNT_W(16), .TS_W(32)
  ) u_dut (
    .clk           (clk),
    .areset        (areset),
    .clear         (clear),
    .sample_valid  (sample_valid),
    .ref_data      (ref_data),
    .dut_data      (dut_data),
    .rd_sel        (rd_sel),
    .ch_mismatch   (ch_mismatch),
    .sample_count  (sample_count),
    .total_errors  (total_errors),
    .any_error     (any_error),
    .rd_errors     (rd_errors),
    .rd_first_time (rd_first_time),
    .rd_first_valid(rd_first_valid)
  );

  mismatch_monitor #(
    .NUM_CH(3), .WIDTH(1), .CNT_W(4), .TS_W(8)
  ) u_sat (
    .clk           (clk),
    .areset        (areset),
    .clear         (clear),
    .sample_valid  (s_valid),
    .ref_data      (s_ref),
    .dut_data      (s_dut),
    .rd_sel        (s_rd_sel),
    .ch_mismatch   (s_ch),
    .sample_count  (s_sc),
    .total_errors  (s_te),
    .any_error     (s_ae),
    .rd_errors     (s_rde),
    .rd_first_time (s_rdt),
    .rd_first_valid(s_rdv)
  );

  typedef struct packed {
    logic [15:0]      sc;
    logic [15:0]      te;
    logic             ae;
    logic [3:0][15:0] err;
    logic [3:0][31:0] ft;
    logic [3:0]       fv;
  } snap_t;

  snap_t       q[$];
  snap_t       m, cur;
  logic [3:0]  m_ch;
  logic [31:0] ts, last_tacc, ts5;
  logic [7:0]  s_first;
  bit          pend;
  int          n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    q.delete();
    m    = '0;
    cur  = '0;
    m_ch = '0;
    pend = 1'b0;
  endtask

  task automatic check_main();
    chk("ch_mismatch", 64'(ch_mismatch), 64'(m_ch));
    chk("sample_count", 64'(sample_count), 64'(cur.sc));
    chk("total_errors", 64'(total_errors), 64'(cur.te));
    chk("any_error", 64'(any_error), 64'(cur.ae));
    chk("rd_errors", 64'(rd_errors), 64'(cur.err[rd_sel]));
    chk("rd_first_valid", 64'(rd_first_valid),
        64'(FT_EN & cur.fv[rd_sel]));
    chk("rd_first_time", 64'(rd_first_time),
        FT_EN ? 64'(cur.ft[rd_sel]) : 64'd0);
  endtask

  // Drive one cycle, update the model at the edge, check 1 ns later.
  task automatic step(input bit v, input logic [3:0] r,
                      input logic [3:0] d, input bit clr = 1'b0,
                      input bit sv = 1'b0,
                      input logic [2:0] sr = 3'd0,
                      input logic [2:0] sd = 3'd0);
    bit          popnow;
    logic [3:0]  mm;
    logic [31:0] tacc;
    sample_valid = v;
    ref_data     = r;
    dut_data     = d;
    clear        = clr;
    s_valid      = sv;
    s_ref        = sr;
    s_dut        = sd;
    rd_sel       = rd_sel + 2'd1;
    @(posedge clk);
    tacc      = ts;
    last_tacc = tacc;
    ts        = clr ? 32'd0 : ts + 32'd1;
    popnow    = pend;
    pend      = v && !clr;
    if (clr) begin
      model_reset();
      popnow = 1'b0;
    end else if (v) begin
      mm   = r ^ d;
      m_ch = mm;
      m.sc = sat16(m.sc);
      if (|mm) begin
        m.te = sat16(m.te);
        m.ae = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (mm[i]) begin
          m.err[i] = sat16(m.err[i]);
          if (!m.fv[i]) begin
            m.fv[i] = 1'b1;
            m.ft[i] = tacc;
          end
        end
      end
      q.push_back(m);
    end
    #1;
    if (popnow) cur = q.pop_front();
    check_main();
  endtask

  task automatic async_reset();
    #2 areset = 1'b1;
    #1;
    chk("rst_sample_count", 64'(sample_count), 64'd0);
    chk("rst_total_errors", 64'(total_errors), 64'd0);
    chk("rst_any_error", 64'(any_error), 64'd0);
    chk("rst_ch_mismatch", 64'(ch_mismatch), 64'd0);
    chk("rst_rd_errors", 64'(rd_errors), 64'd0);
    chk("rst_rd_first_valid", 64'(rd_first_valid), 64'd0);
    chk("rst_rd_first_time", 64'(rd_first_time), 64'd0);
    model_reset();
    ts = 32'd0;
    @(posedge clk);
    #1 areset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    areset       = 1'b1;
    clear        = 1'b0;
    sample_valid = 1'b0;
    ref_data     = '0;
    dut_data     = '0;
    rd_sel       = '0;
    s_valid      = 1'b0;
    s_ref        = '0;
    s_dut        = '0;
    s_rd_sel     = '0;
    ts           = '0;
    ts5          = '0;
    s_first      = '0;
    model_reset();
    #1;
    chk("init_sample_count", 64'(sample_count), 64'd0);
    chk("init_any_error", 64'(any_error), 64'd0);
    chk("init_rd_first_valid", 64'(rd_first_valid), 64'd0);
    @(posedge clk);
    #1 areset = 1'b0;
    step(1'b0, 4'h0, 4'h0);

    // Counting pattern, channel 2 flipped on values 5 and 9.
    for (int v = 0; v < 16; v++) begin
      logic [3:0] r;
      r = 4'(v);
      step(1'b1, r, (v == 5 || v == 9) ? r ^ 4'b0100 : r);
      if (v == 5) ts5 = last_tacc;
    end
    step(1'b0, 4'h0, 4'h0);
    step(1'b0, 4'h0, 4'h0);
    chk("cnt_sample_count", 64'(sample_count), 64'd16);
    chk("cnt_total_errors", 64'(total_errors), 64'd2);
    rd_sel = 2'd2;
    #1;
    chk("cnt_err2", 64'(rd_errors), 64'd2);
    chk("cnt_first_time2", 64'(rd_first_time),
        FT_EN ? 64'(ts5) : 64'd0);
    chk("cnt_first_valid2", 64'(rd_first_valid), 64'(FT_EN));
    for (int c = 0; c < 4; c++) begin
      if (c != 2) begin
        rd_sel = 2'(c);
        #1;
        chk("cnt_err_other", 64'(rd_errors), 64'd0);
      end
    end

    // Idle gaps: ch_mismatch holds, counts move only on valid samples.
    step(1'b1, 4'h0, 4'h3);
    step(1'b0, 4'hf, 4'h0);
    step(1'b0, 4'hf, 4'h0);
    chk("gap_hold", 64'(ch_mismatch), 64'h3);
    step(1'b1, 4'h5, 4'h5);
    step(1'b0, 4'h0, 4'h0);

    for (int k = 0; k < 40; k++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom),
           4'($urandom));
    end

    async_reset();
    step(1'b1, 4'h0, 4'h9);
    step(1'b1, 4'h1, 4'h1);
    step(1'b1, 4'h0, 4'hf, 1'b1);
    step(1'b0, 4'h0, 4'h0);
    chk("clr_sample_count", 64'(sample_count), 64'd0);
    chk("clr_any_error", 64'(any_error), 64'd0);
    chk("clr_ch_mismatch", 64'(ch_mismatch), 64'd0);
    step(1'b0, 4'h0, 4'h0);
    chk("clr_total_errors", 64'(total_errors), 64'd0);

    // Saturation on the CNT_W=4 instance.
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 3'b000, 3'b111);
      if (k == 0) s_first = last_tacc[7:0];
    end
    step(1'b0, 4'h0, 4'h0);
    step(1'b0, 4'h0, 4'h0);
    chk("sat_sample_count", 64'(s_sc), 64'd15);
    chk("sat_total_errors", 64'(s_te), 64'd15);
    chk("sat_any_error", 64'(s_ae), 64'd1);
    chk("sat_ch_mismatch", 64'(s_ch), 64'h7);
    for (int c = 0; c < 3; c++) begin
      s_rd_sel = 2'(c);
      #1;
      chk("sat_rd_errors", 64'(s_rde), 64'd15);
      chk("sat_rd_first_valid", 64'(s_rdv), 64'(FT_EN));
      chk("sat_rd_first_time", 64'(s_rdt),
          FT_EN ? 64'(s_first) : 64'd0);
    end
    s_rd_sel = 2'd3;
    #1;
    chk("oor_rd_errors", 64'(s_rde), 64'd0);
    chk("oor_rd_first_time", 64'(s_rdt), 64'd0);
    chk("oor_rd_first_valid", 64'(s_rdv), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mismatch_monitor.md
# mismatch_monitor

Synthesizable, parametrised successor to the per-output mismatch bookkeeping our benches do around each reference/DUT pair. It compares NUM_CH reference channels against NUM_CH DUT channels on every qualified sample and keeps:
- a per-channel saturating error count;
- a total sample count and a total mismatched-sample count;
- a per-channel first-mismatch timestamp, taken from an internal free-running cycle counter.

It sits between a stimulus generator and the readout logic of a hardware regression harness.

## Interface
- NUM_CH, 4, number of compared channels (≥1)
- WIDTH, 1, bits per channel (≥1)
- CNT_W, 16, width of every count
- TS_W, 32, width of cycle counter / timestamps
- SEL_W, $clog2(NUM_CH) (min 1), readout select width
- clk  in  1  single clock, all state on rising edge
- areset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear of all statistics and pipeline
- sample_valid  in  1  sample qualifier
- ref_data  in  NUM_CH*WIDTH  reference vector; channel i = bits [i*WIDTH +: WIDTH]
- dut_data  in  NUM_CH*WIDTH  DUT vector, same packing
- rd_sel  in  SEL_W  channel select for readout
- ch_mismatch  out  NUM_CH  registered per-channel mismatch of last valid sample
- sample_count  out  CNT_W  valid samples processed
- total_errors  out  CNT_W  valid samples with ≥1 mismatching channel
- any_error  out  1  sticky; set on first mismatch
- rd_errors  out  CNT_W  error count of channel rd_sel
- rd_first_time  out  TS_W  first-mismatch timestamp of channel rd_sel
- rd_first_valid  out  1  channel rd_sel has recorded a mismatch

## Operation
- The timestamp counter increments every cycle and wraps modulo 2^TS_W.
- **Stage 1** (registered when sample_valid=1):
  - mismatch bit i = (ref channel i != dut channel i);
  - stores the mismatch vector, valid_q and the current timestamp;
  - ch_mismatch updates only on valid samples and holds otherwise.
- **Stage 2** (when valid_q=1):
  - sample_count += 1;
  - total_errors += 1 if any bit of the vector is set;
  - for each set bit i: errors[i] += 1;
  - if first_valid[i]=0, capture first_time[i] from the stage-1 timestamp and set first_valid[i];
  - any_error is set when any bit is set.
- All counts saturate at 2^CNT_W-1 and never wrap. sample_count saturating does not block error counting.
- first_time is written once per channel and never overwritten until clear or areset.
- Readout (rd_errors, rd_first_time, rd_first_valid) is a combinational mux of registered state. If rd_sel ≥ NUM_CH, all three read 0.
- clear=1:
  - zeroes all counts, first_valid, any_error, ch_mismatch and valid_q, and the timestamp counter;
  - a sample_valid in the same cycle is dropped;
  - clear takes priority over any stage-2 update.

## Timing
- areset forces every register to 0 immediately. Every output reads 0, including any_error and rd_first_valid.
- A sample presented at edge N appears on ch_mismatch after edge N. It is reflected in the counts and first_time after edge N+1, i.e. 2-cycle latency.
- Back-to-back valid samples are accepted every cycle; there is no backpressure.
- The recorded timestamp is the counter value at edge N, the sample's acceptance edge.
- areset deasserted mid-stream: the first sample accepted is the one valid at the first rising edge with areset low.

## Configuration
- MISMATCH_MONITOR_FIRST_TIME_EN defined: the timestamp counter and per-channel first_time/first_valid registers exist as described.
- Not defined: the counter and those registers are omitted. rd_first_time and rd_first_valid are tied to 0; all other behaviour is identical.

## Structure
- mismatch_monitor_pkg holds:
  - the ch_stats_t struct (errors, first_time, first_valid), parametrised via localparams;
  - a saturating-increment function;
  - the readout-zero constant.
- One sub-module, mismatch_channel, instantiated NUM_CH times. It holds one channel's counter and first-mismatch capture and is fed by the stage-1 bit, valid_q, timestamp and clear.

## Test plan
- areset pulse mid-run with counts nonzero -> all outputs 0 asynchronously, before the next edge.
- NUM_CH=4, WIDTH=1: count {a,b,c,d} 0..15 as ref; dut = ref with channel 2 inverted on values 5 and 9 only -> after drain: sample_count=16, total_errors=2, errors[2]=2, others 0, rd_first_time of channel 2 = acceptance cycle of value 5.
- CNT_W=4: mismatch every cycle for 20 valid samples -> sample_count, total_errors and errors[i] all stick at 15.
- clear asserted together with a mismatching sample_valid -> next cycle all counts 0, any_error=0, sample dropped.
- Idle gaps (sample_valid=0) between samples -> counts change only for valid samples; ch_mismatch holds its last value.
- rd_sel=NUM_CH (NUM_CH=3, SEL_W=2) -> rd_errors=0, rd_first_time=0, rd_first_valid=0.
